// File: rtl/word_store_sequencer_pkg.sv
// Shared CPU constants: store-sequencer state encoding and the byte-select
// encoding used by the instruction register's HighSel.
package cpu_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WR_FIRST  = 2'd1;
   localparam logic [1:0] ST_WR_SECOND = 2'd2;
   localparam logic [1:0] ST_DONE      = 2'd3;

   localparam logic BYTE_LOW  = 1'b0;
   localparam logic BYTE_HIGH = 1'b1;

endpackage

// File: rtl/word_store_sequencer_if.sv
// Request and byte-memory write port of the word store sequencer.
interface word_store_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [15:0]       word_in;
   logic [ADDR_W-1:0] addr_in;
   logic              mem_ready;
   logic              busy;
   logic              done;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              byte_sel;

   modport master (
      output start, word_in, addr_in, mem_ready,
      input  busy, done, mem_we, mem_addr, mem_data, byte_sel
   );

   modport slave (
      input  start, word_in, addr_in, mem_ready,
      output busy, done, mem_we, mem_addr, mem_data, byte_sel
   );
endinterface

// File: rtl/word_store_sequencer.sv
// Stores a 16-bit word as two byte writes, little-endian (low byte at A,
// high byte at A+1). Outputs decode only from registered state and latched data.
module word_store_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter bit HIGH_FIRST = 1'b0
) (
   input logic                   clock,
   input logic                   reset,
   word_store_sequencer_if.slave bus
);

   logic [1:0]        state_q, state_d;
   logic [15:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_active;
   logic              sel;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_WR_FIRST;
               word_d  = bus.word_in;
               addr_d  = bus.addr_in;
            end
         end
         ST_WR_FIRST:  if (bus.mem_ready) state_d = ST_WR_SECOND;
         ST_WR_SECOND: if (bus.mem_ready) state_d = ST_DONE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
      end
   end

   // The high byte is in flight in the first write slot exactly when HIGH_FIRST is set.
   assign wr_active = (state_q == ST_WR_FIRST) || (state_q == ST_WR_SECOND);
   assign sel       = ((state_q == ST_WR_FIRST) == HIGH_FIRST) ? BYTE_HIGH : BYTE_LOW;

   assign bus.busy     = wr_active;
   assign bus.mem_we   = wr_active;
   assign bus.done     = (state_q == ST_DONE);
   assign bus.byte_sel = wr_active & sel;
   // A+1 wraps modulo 2^ADDR_W; no carry is reported.
   assign bus.mem_addr = wr_active ? addr_q + ADDR_W'(sel) : '0;
   assign bus.mem_data = !wr_active ? 8'h00 :
                         (sel == BYTE_HIGH) ? word_q[15:8] : word_q[7:0];

endmodule
